// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared core types (RAM word/state) plus arbiter state encoding and default starvation limit
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, ISERV, DSERV, RETRY} arb_state_t;
  localparam int ARB_STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive data grants made while fetch waits
//   i_clk, i_rst_n : clock, async active-low reset
//   i_inc, i_clr   : count one data grant / clear on fetch grant (clear wins)
//   o_lim          : count has reached LIMIT
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_lim
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  logic [W-1:0] r_cnt;
  assign o_lim = r_cnt >= LIM;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_lim) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency RAM port between instruction fetch and data load/store
//   CLK, nRST                        : clock, async active-low reset
//   iREN/iaddr -> iwait/iload        : fetch port
//   dREN/dWEN/daddr/dstore -> dwait/dload : data port
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate : RAM port
//   busy                             : arbiter not idle
//   Macro ARB_FAIR_EN: fetch wins after STARVE_LIMIT consecutive data grants while it waits.
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              busy
);
  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_addr, r_data;
  logic              r_wr, r_dport, r_ramren, r_ramwen;
  logic              w_dreq, w_dgrant, w_idone, w_ddone;
  assign w_dreq = dREN | dWEN;
`ifdef ARB_FAIR_EN
  logic w_lim;
  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .i_clk  (CLK),
    .i_rst_n(nRST),
    .i_inc  (r_state == IDLE && w_dgrant && iREN),
    .i_clr  (r_state == IDLE && !w_dgrant && iREN),
    .o_lim  (w_lim)
  );
  assign w_dgrant = w_dreq && !(w_lim && iREN);
`else
  assign w_dgrant = w_dreq;
`endif
  assign w_idone  = r_state == ISERV && ramstate == ACCESS;
  assign w_ddone  = r_state == DSERV && ramstate == ACCESS;
  assign iwait    = iREN && !w_idone;
  assign dwait    = w_dreq && !w_ddone;
  // a requester that has already dropped its request gets nothing back
  assign iload    = (w_idone && iREN) ? ramload : '0;
  assign dload    = (w_ddone && w_dreq) ? ramload : '0;
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_addr;
  assign ramstore = r_data;
  assign busy     = r_state != IDLE;
  // strobes are registered alongside the state so they follow the next state exactly
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_wr     <= 1'b0;
      r_dport  <= 1'b0;
      r_ramren <= 1'b0;
      r_ramwen <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (w_dgrant) begin
            r_state  <= DSERV;
            r_addr   <= daddr;
            r_data   <= dstore;
            r_wr     <= dWEN;
            r_dport  <= 1'b1;
            r_ramren <= !dWEN;
            r_ramwen <= dWEN;
          end else if (iREN) begin
            r_state  <= ISERV;
            r_addr   <= iaddr;
            r_wr     <= 1'b0;
            r_dport  <= 1'b0;
            r_ramren <= 1'b1;
            r_ramwen <= 1'b0;
          end
        ISERV, DSERV:
          if (ramstate == ACCESS || ramstate == ERROR) begin
            r_state  <= ramstate == ACCESS ? IDLE : RETRY;
            r_ramren <= 1'b0;
            r_ramwen <= 1'b0;
          end
        RETRY: begin
          r_state  <= r_dport ? DSERV : ISERV;
          r_ramren <= !r_wr;
          r_ramwen <= r_wr;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN, busy;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int          errors = 0, checks = 0;
  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  initial begin
    // 1: reset, then single-cycle fetch
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h8C220004;
    #3;
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 0);
    chk("rst_ramren", ramREN, 0); chk("rst_busy", busy, 0);
    @(posedge CLK); @(posedge CLK); #2;
    nRST = 1'b1; #1;
    chk("idle_iwait", iwait, 1); chk("idle_ramren", ramREN, 0);
    tick(); #1;
    chk("t1_ramren", ramREN, 1); chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", iwait, 0); chk("t1_iload", iload, 32'h8C220004); chk("t1_busy", busy, 1);
    tick(); iREN = 1'b0; #1;
    chk("t1_idle_ramren", ramREN, 0); chk("t1_idle_busy", busy, 0);
    // 2: simultaneous requests, data first
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY; #1;
    chk("t2_dwait0", dwait, 1); chk("t2_iwait0", iwait, 1);
    tick(); #1;
    chk("t2_ramren", ramREN, 1); chk("t2_ramaddr", ramaddr, 32'h100); chk("t2_dwait1", dwait, 1);
    tick(); #1;
    chk("t2_hold_ramren", ramREN, 1); chk("t2_hold_dwait", dwait, 1); chk("t2_hold_dload", dload, 0);
    ramstate = ACCESS; ramload = 32'h11112222; #1;
    chk("t2_dwait_done", dwait, 0); chk("t2_dload", dload, 32'h11112222);
    chk("t2_iwait_still", iwait, 1); chk("t2_iload_zero", iload, 0);
    tick(); dREN = 1'b0; ramstate = BUSY; #1;
    chk("t2_gap_busy", busy, 0); chk("t2_gap_ramren", ramREN, 0);
    tick(); #1;
    chk("t2_iserv_ramren", ramREN, 1); chk("t2_iserv_addr", ramaddr, 32'h80);
    ramstate = ACCESS; ramload = 32'h33334444; #1;
    chk("t2_iload", iload, 32'h33334444); chk("t2_iwait_done", iwait, 0);
    tick(); iREN = 1'b0; ramstate = BUSY; #1;
    // 3: write (dWEN overrides dREN)
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick(); #1;
    chk("t3_ramwen", ramWEN, 1); chk("t3_ramren", ramREN, 0);
    chk("t3_ramstore", ramstore, 32'hDEADBEEF); chk("t3_ramaddr", ramaddr, 32'h200);
    tick(); #1;
    chk("t3_hold_ramwen", ramWEN, 1); chk("t3_hold_dwait", dwait, 1);
    ramstate = ACCESS; #1;
    chk("t3_dwait_done", dwait, 0);
    tick(); dWEN = 1'b0; dREN = 1'b0; #1;
    chk("t3_idle_ramwen", ramWEN, 0);
    // 4: error and retry on fetch
    iREN = 1'b1; iaddr = 32'h300; ramstate = ERROR;
    tick(); #1;
    chk("t4_ramren", ramREN, 1); chk("t4_iwait_err", iwait, 1);
    tick(); ramstate = BUSY; #1;
    chk("t4_retry_ramren", ramREN, 0); chk("t4_retry_busy", busy, 1); chk("t4_retry_iwait", iwait, 1);
    tick(); #1;
    chk("t4_again_ramren", ramREN, 1); chk("t4_again_addr", ramaddr, 32'h300);
    ramstate = ACCESS; ramload = 32'h55; #1;
    chk("t4_iload", iload, 32'h55); chk("t4_iwait_done", iwait, 0);
    tick(); iREN = 1'b0; ramstate = BUSY; #1;
    // 5: async reset mid-transaction
    dREN = 1'b1; daddr = 32'h400;
    tick(); #1;
    chk("t5_ramren", ramREN, 1);
    nRST = 1'b0; #1;
    chk("t5_rst_ramren", ramREN, 0); chk("t5_rst_ramwen", ramWEN, 0); chk("t5_rst_busy", busy, 0);
    dREN = 1'b0; #1; nRST = 1'b1;
    tick(); #1;
    chk("t5_after_busy", busy, 0);
    // 6: fetch starvation with continuous data requests
    iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600; ramstate = ACCESS;
    for (int g = 0; g < 5; g++) begin
      tick(); #1;
`ifdef ARB_FAIR_EN
      chk($sformatf("t6_grant%0d", g), ramaddr, g == 4 ? 32'h500 : 32'h600);
`else
      chk($sformatf("t6_grant%0d", g), ramaddr, 32'h600);
`endif
      chk($sformatf("t6_busy%0d", g), busy, 1);
      tick(); #1;
      chk($sformatf("t6_idle%0d", g), busy, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
